// File: rtl/data_memory.sv
// data_memory
//   Byte-addressable data memory for the load/store path. Requests use a
//   valid/ready handshake; stores commit on the acceptance edge, loads capture
//   the addressed word on the acceptance edge and respond READ_LATENCY cycles
//   later. Byte and half accesses are lane-aligned and sign/zero-extended.
//   Misaligned, reserved-size and out-of-range accesses are faulted.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   req_valid     request present
//   req_ready     request can be accepted this cycle
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  zero-extend byte/half loads
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle response pulse
//   resp_rdata    load result (0 for stores and faults)
//   resp_fault    access rejected, qualified by resp_valid
module data_memory #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Initial counter value for a valid load; 0 means respond next cycle.
    localparam logic [1:0] LOAD_CNT = 2'(READ_LATENCY - 1);

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [1:0]    cnt;
    logic          accept;
    logic [AW-1:0] word_idx;

    logic          fault_p0;
    logic [3:0]    be_p0;
    logic [31:0]   wlanes_p0;
    logic [31:0]   rdata_p0;
    logic [1:0]    cnt_p0;

    logic          fault_p1;
    logic [31:0]   rdata_p1;

    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{~uns & word[7]}},  word[7:0]};
            2'b01:   r = {{16{~uns & word[15]}}, word[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Ready is forced low during reset so nothing is accepted or written.
    assign req_ready = reset && (state != BUSY);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW+1:2];

    // ---- stage p0: decode of the request presented this cycle ----
    always_comb begin
        fault_p0 = 1'b0;
        case (req_size)
            2'b01:   fault_p0 = req_addr[0];
            2'b10:   fault_p0 = |req_addr[1:0];
            2'b11:   fault_p0 = 1'b1;
            default: fault_p0 = 1'b0;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH)) begin
            fault_p0 = 1'b1;
        end

        // Store data is replicated across lanes; byte enables pick the lanes.
        be_p0     = 4'b1111;
        wlanes_p0 = req_wdata;
        case (req_size)
            2'b00: begin
                be_p0     = 4'b0001 << req_addr[1:0];
                wlanes_p0 = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_p0     = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes_p0 = {2{req_wdata[15:0]}};
            end
            default: begin
                be_p0     = 4'b1111;
                wlanes_p0 = req_wdata;
            end
        endcase

        // The word index is only meaningful when the access does not fault.
        if (fault_p0 || req_we) begin
            rdata_p0 = 32'd0;
        end else begin
            rdata_p0 = extend(mem[word_idx] >> {req_addr[1:0], 3'b000},
                              req_size, req_unsigned);
        end

        cnt_p0 = (fault_p0 || req_we) ? 2'd0 : LOAD_CNT;
    end

    always_ff @(posedge clock) begin
        if (accept && req_we && !fault_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_p0[b]) begin
                    mem[word_idx][8*b +: 8] <= wlanes_p0[8*b +: 8];
                end
            end
        end
    end

    // ---- stage p1: response held while the latency counter runs ----
    always_ff @(posedge clock) begin
        if (accept) begin
            rdata_p1 <= rdata_p0;
            fault_p1 <= fault_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            if (accept) begin
                cnt <= cnt_p0;
                if (cnt_p0 == 2'd0) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= rdata_p0;
                    resp_fault <= fault_p0;
                end else begin
                    state <= BUSY;
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 2'd1;
                // Counter reaching zero on this edge means the response is due.
                if (cnt == 2'd1) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= rdata_p1;
                    resp_fault <= fault_p1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
//   Drives three data_memory instances (READ_LATENCY 1, 3 and 4) and checks
//   responses against a byte-array reference model of the memory.
module tb_data_memory;

    localparam int D = 256;

    logic             clock;
    logic [2:0]       rst_n;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0]       req_we;
    logic [2:0][1:0]  req_size;
    logic [2:0]       req_unsigned;
    logic [2:0][31:0] req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0]       resp_valid;
    logic [2:0][31:0] resp_rdata;
    logic [2:0]       resp_fault;

    int tests = 0;
    int fails = 0;
    int rl [3] = '{1, 3, 4};
    logic [7:0] mdl [3][4*D];

    data_memory #(.DEPTH(D), .READ_LATENCY(1)) dut0 (
        .clock(clock), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]));

    data_memory #(.DEPTH(D), .READ_LATENCY(3)) dut1 (
        .clock(clock), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]));

    data_memory #(.DEPTH(D), .READ_LATENCY(4)) dut2 (
        .clock(clock), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_rdata(resp_rdata[2]), .resp_fault(resp_fault[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: memory as a flat byte array, loads assembled little-endian.
    task automatic model_op(input int s, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            output logic [31:0] er, output logic ef);
        int nb;
        int a;
        longint v;
        er = 32'd0;
        ef = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(4*D));
        if (ef) return;
        nb = 1 << size;
        a  = int'(addr);
        if (we) begin
            for (int i = 0; i < nb; i++) mdl[s][a+i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(mdl[s][a+i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
            er = v[31:0];
        end
    endtask

    task automatic xact(input int s, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] got, output logic gotf);
        logic [31:0] er;
        logic ef;
        int n;
        int lat;
        int el;
        req_we[s] = we; req_size[s] = size; req_unsigned[s] = uns;
        req_addr[s] = addr; req_wdata[s] = wdata; req_valid[s] = 1'b1;
        got = 32'd0; gotf = 1'b0;
        n = 0;
        while (req_ready[s] !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL %s dut%0d ready timeout: ready=%b, required 1", tag, s, req_ready[s]);
            req_valid[s] = 1'b0;
            return;
        end
        @(posedge clock); #1;
        req_valid[s] = 1'b0;
        model_op(s, we, size, uns, addr, wdata, er, ef);
        el = (ef || we) ? 1 : rl[s];
        lat = 1;
        while (resp_valid[s] !== 1'b1 && lat < 8) begin @(posedge clock); #1; lat++; end
        got = resp_rdata[s];
        gotf = resp_fault[s];
        if (lat != el) begin
            fails++;
            $display("FAIL %s dut%0d latency: got %0d, required %0d", tag, s, lat, el);
        end
        tests++;
        if (got !== er) begin
            fails++;
            $display("FAIL %s dut%0d rdata: got %h, required %h", tag, s, got, er);
        end
        tests++;
        if (gotf !== ef) begin
            fails++;
            $display("FAIL %s dut%0d fault: got %b, required %b", tag, s, gotf, ef);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic gf;
        req_valid = 3'b111; req_we = 3'b111;
        for (int s = 0; s < 3; s++) begin
            req_size[s] = 2'b10; req_addr[s] = 32'h40; req_wdata[s] = 32'hDEADBEEF;
        end
        repeat (2) begin
            @(posedge clock); #1;
            for (int s = 0; s < 3; s++) begin
                tests++;
                if ({req_ready[s], resp_valid[s], resp_fault[s]} !== 3'b000 || resp_rdata[s] !== 32'd0) begin
                    fails++;
                    $display("FAIL reset_outputs dut%0d: ready=%b valid=%b fault=%b rdata=%h, required all 0",
                             s, req_ready[s], resp_valid[s], resp_fault[s], resp_rdata[s]);
                end
            end
        end
        req_valid = 3'b000;
        rst_n = 3'b111;
        #1;
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (req_ready[s] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release_ready dut%0d: got %b, required 1", s, req_ready[s]);
            end
        end
        // A store presented during reset must not reach the array.
        xact(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, "rst_sw_known", got, gf);
        rst_n[0] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10;
        req_addr[0] = 32'h40; req_wdata[0] = 32'hDEADBEEF;
        repeat (2) begin
            @(posedge clock); #1;
            tests++;
            if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold dut0: ready=%b valid=%b, required 0 0", req_ready[0], resp_valid[0]);
            end
        end
        req_valid[0] = 1'b0;
        rst_n[0] = 1'b1;
        #1;
        xact(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "rst_no_write", got, gf);
        tests++;
        if (got !== 32'h11111111) begin
            fails++;
            $display("FAIL reset_no_write: got %h, required 11111111", got);
        end
    endtask

    task automatic test_subword();
        logic [31:0] got;
        logic gf;
        logic [31:0] exp_v [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'hBEEF7F01};
        logic [31:0] got_v [5];
        xact(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, "sw_10", got, gf);
        xact(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "lb_11", got_v[0], gf);
        xact(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb_13", got_v[1], gf);
        xact(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu_13", got_v[2], gf);
        xact(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lh_12", got_v[3], gf);
        xact(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, "sh_12", got, gf);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_10", got_v[4], gf);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_v[i] !== exp_v[i]) begin
                fails++;
                $display("FAIL subword_%0d: got %h, required %h", i, got_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] got;
        logic [31:0] er;
        logic ef;
        logic gf;
        xact(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, "lat_sw", got, gf);
        req_we[1] = 1'b0; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h0; req_valid[1] = 1'b1;
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        model_op(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, er, ef);
        for (int c = 1; c <= 2; c++) begin
            tests++;
            if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
                fails++;
                $display("FAIL lat_busy_k+%0d: ready=%b valid=%b, required 0 0", c, req_ready[1], resp_valid[1]);
            end
            @(posedge clock); #1;
        end
        tests++;
        if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== er || req_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL lat_resp_k+3: valid=%b ready=%b rdata=%h, required 1 1 %h",
                     resp_valid[1], req_ready[1], resp_rdata[1], er);
        end
        xact(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0BADF00D, "lat_store", got, gf);
        xact(1, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, "lat_lhu", got, gf);
    endtask

    task automatic test_faults();
        logic [31:0] got;
        logic gf;
        logic [31:0] fa [4] = '{32'h2, 32'h5, 32'h8, 32'(4*D)};
        logic        fw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]  fs [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] keep [3] = '{32'h01234567, 32'h89ABCDEF, 32'h55AA55AA};
        for (int i = 0; i < 3; i++) xact(0, 1'b1, 2'b10, 1'b0, 32'(4*i), keep[i], "flt_init", got, gf);
        for (int i = 0; i < 4; i++) begin
            xact(0, fw[i], fs[i], 1'b0, fa[i], 32'hFFFFFFFF, "flt_req", got, gf);
            tests++;
            if (gf !== 1'b1 || got !== 32'd0) begin
                fails++;
                $display("FAIL fault_%0d: fault=%b rdata=%h, required 1 00000000", i, gf, got);
            end
        end
        for (int i = 0; i < 3; i++) begin
            xact(0, 1'b0, 2'b10, 1'b0, 32'(4*i), 32'h0, "flt_reread", got, gf);
            tests++;
            if (got !== keep[i]) begin
                fails++;
                $display("FAIL fault_unchanged_%0d: got %h, required %h", i, got, keep[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er;
        logic ef;
        req_we[0] = 1'b1; req_size[0] = 2'b10; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5A5A5; req_valid[0] = 1'b1;
        @(posedge clock); #1;
        model_op(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, er, ef);
        tests++;
        if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: valid=%b ready=%b, required 1 1", resp_valid[0], req_ready[0]);
        end
        req_we[0] = 1'b0; req_wdata[0] = 32'h0;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        model_op(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, er, ef);
        tests++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL b2b_second: valid=%b rdata=%h, required 1 a5a5a5a5", resp_valid[0], resp_rdata[0]);
        end
        @(posedge clock); #1;
        tests++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || resp_fault[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_after: valid=%b rdata=%h fault=%b, required 0 00000000 0",
                     resp_valid[0], resp_rdata[0], resp_fault[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] got;
        logic gf;
        int seen;
        xact(2, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, "mid_sw", got, gf);
        req_we[2] = 1'b0; req_size[2] = 2'b10; req_addr[2] = 32'h4; req_valid[2] = 1'b1;
        @(posedge clock); #1;
        req_valid[2] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        rst_n[2] = 1'b0;
        seen = 0;
        @(posedge clock); #1;
        if (resp_valid[2] === 1'b1) seen++;
        rst_n[2] = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
            if (resp_valid[2] === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_reset_dropped: resp_valid seen %0d cycles, required 0", seen);
        end
        xact(2, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, "mid_after", got, gf);
        tests++;
        if (got !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL mid_reset_store_kept: got %h, required cafef00d", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic gf;
        logic [31:0] addr;
        logic [1:0] size;
        int r;
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < 16; w++) xact(s, 1'b1, 2'b10, 1'b0, 32'(4*w), $urandom(), "rnd_init", got, gf);
            for (int t = 0; t < 40; t++) begin
                r = $urandom_range(0, 9);
                size = (r == 9) ? 2'b11 : 2'(r % 3);
                if ($urandom_range(0, 7) == 0)
                    addr = ($urandom_range(0, 1) == 0) ? 32'(4*D) + 32'($urandom_range(0, 4095))
                                                       : ($urandom() | 32'h80000000);
                else
                    addr = 32'($urandom_range(0, 63));
                xact(s, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom(),
                     "rnd", got, gf);
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            end
        end
    endtask

    initial begin
        rst_n = 3'b000; req_valid = '0; req_we = '0; req_size = '0;
        req_unsigned = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_subword();
        test_latency();
        test_faults();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised byte-addressable data memory for the RISC-V core's load/store path. It adds four things to the single-cycle word array: a valid/ready request handshake, a configurable read latency, RV32I sub-word accesses with sign/zero extension, and fault reporting for misaligned or out-of-range accesses. It sits between the memory stage and the stall logic, so the pipeline sees a fixed, parameter-defined read delay.

## Interface
- DEPTH, 1024: number of 32-bit words; byte address range is 0 to 4·DEPTH−1.
- READ_LATENCY, 1: cycles from read acceptance to response, range 1–4.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for word and store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, aligned and extended; 0 for stores and faults.
- resp_fault  out  1  access rejected; valid with resp_valid.

## Operation
- A request is accepted on a clock edge where req_valid=1, req_ready=1 and reset=1.
- Fault conditions, checked on the accepted request:
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:2] ≥ DEPTH.
- A faulting access writes nothing and responds with resp_fault=1, resp_rdata=0.
- Store: commits on the acceptance edge with per-byte lane enables.
  - SB: lane addr[1:0] ← wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0], little-endian.
  - SW: all four lanes.
  - Untouched lanes keep their value.
- Load: the word at addr[31:2] is read and shifted right by 8·addr[1:0].
  - Byte/half results are sign-extended, or zero-extended if req_unsigned=1.
  - The word is captured at the acceptance edge, so the data is as of that edge.
- FSM:
  - IDLE: req_ready=1.
  - Accept → BUSY with counter=latency−1, where latency=1 for stores and faults and READ_LATENCY for valid loads. If that value is 0, go straight to RESP.
  - BUSY: req_ready=0; counter decrements each cycle; at 0 → RESP.
  - RESP: resp_valid=1, req_ready=1. A new accept goes to BUSY/RESP as above; otherwise → IDLE.
- The response has no backpressure.
- Reset does not clear memory contents.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_fault=0, state IDLE, counter 0. req_ready=0 while reset=0.
- Reset asserted mid-operation:
  - The pending response is dropped; no resp_valid on the following cycles.
  - A store already committed remains.
- Acceptance at edge k:
  - Store/fault response: resp_valid high in cycle k+1.
  - Load response: resp_valid high in cycle k+READ_LATENCY.
- Throughput is one request per response. With READ_LATENCY=1, back-to-back requests are accepted every cycle.
- Read-after-write: a load accepted in the store's RESP cycle returns the new data.
- resp_rdata and resp_fault are registered. They hold their values only while resp_valid=1 and return to 0 afterwards.

## Test plan
- Reset: hold reset=0 for 2 cycles with req_valid=1 → req_ready=0, resp_valid=0, no write performed; after release, req_ready=1.
- Sub-word store/load, READ_LATENCY=1:
  - SW 0x80FF7F01 @0x10, then LB @0x11 → 0x0000007F; LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LH @0x12 → 0xFFFF80FF.
  - SH 0xBEEF @0x12, then LW @0x10 → 0xBEEF7F01.
- Latency, READ_LATENCY=3: LW accepted at edge k → req_ready=0 in k+1 and k+2; resp_valid only in k+3. A store issued at the same point responds in k+1.
- Faults: each of LW @0x2, SH @0x5, size=11, LW @4·DEPTH → resp_fault=1, resp_rdata=0; a following LW of the targeted word shows it unchanged.
- Back-to-back, READ_LATENCY=1: SW 0xA5A5A5A5 @0x20 then LW @0x20 on consecutive cycles → the second response returns 0xA5A5A5A5; resp_valid is high for 2 consecutive cycles.
- Reset mid-read, READ_LATENCY=4: assert reset=0 two cycles after accepting a LW → resp_valid never asserts; after release the next LW completes normally.
